// File: rtl/fetch_byte_queue_pkg.sv
// rtl/fetch_byte_queue_pkg.sv - shared constants and FSM encoding for the fetch byte queue
package fetch_byte_queue_pkg;
    localparam int LINE_BYTES = 16;
    localparam int WIN_BYTES  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FIRST = 2'b01,
        ST_RUN   = 2'b10
    } fbq_state_e;
endpackage

// File: rtl/fetch_byte_queue_byte_window_rotator.sv
// rtl/fetch_byte_queue_byte_window_rotator.sv - log-shifter selecting a byte window from the line ring
module byte_window_rotator
    import fetch_byte_queue_pkg::*;
#(
    parameter int N_BYTES = 64,
    parameter int SH_W    = 6
) (
    input  logic [8*N_BYTES-1:0] i_bytes,
    input  logic [SH_W-1:0]      i_shift,
    output logic [8*WIN_BYTES-1:0] o_window
);
    logic [8*N_BYTES-1:0] w_stage [SH_W+1];

    assign w_stage[0] = i_bytes;

    // Stage s rotates the ring down by 2**s bytes, so byte i_shift lands at position 0.
    for (genvar s = 0; s < SH_W; s++) begin : g_stage
        localparam int SH = 2 ** s;
        assign w_stage[s+1] = i_shift[s]
            ? {w_stage[s][8*SH-1:0], w_stage[s][8*N_BYTES-1:8*SH]}
            : w_stage[s];
    end

    // Head byte goes to the most significant lane of the window.
    for (genvar i = 0; i < WIN_BYTES; i++) begin : g_lane
        assign o_window[8*(WIN_BYTES-1-i) +: 8] = w_stage[SH_W][8*i +: 8];
    end
endmodule

// File: rtl/fetch_byte_queue.sv
// rtl/fetch_byte_queue.sv - line-fill byte queue presenting a 16-byte instruction window to decode
module fetch_byte_queue
    import fetch_byte_queue_pkg::*;
#(
    parameter int DEPTH_LINES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         redirect,
    input  logic [31:0]  redirect_eip,
    input  logic [15:0]  redirect_cs,
    output logic [31:0]  fetch_addr,
    input  logic         fill_valid,
    input  logic [127:0] fill_data,
    output logic         fill_ready,
    output logic         ir_valid,
    output logic [127:0] IR,
    output logic [31:0]  EIP_OUT,
    output logic [15:0]  CS_OUT,
    input  logic         consume,
    input  logic [3:0]   instr_length
);
    localparam int PTR_W = $clog2(DEPTH_LINES);
    localparam int RD_W  = PTR_W + 4;
    localparam int CNT_W = RD_W + 1;
    localparam int TOTAL = DEPTH_LINES * LINE_BYTES;

    logic [127:0]     r_mem [DEPTH_LINES];
    fbq_state_e       r_state, w_state_next;
    logic [PTR_W-1:0] r_wr_ptr, w_wr_ptr_next;
    logic [RD_W-1:0]  r_rd_ptr, w_rd_ptr_next;
    logic [CNT_W-1:0] r_byte_cnt, w_byte_cnt_next;
    logic [31:0]      r_fetch_addr, w_fetch_addr_next;
    logic [31:0]      r_eip, w_eip_next;
    logic [15:0]      r_cs, w_cs_next;
    logic             w_fill_ready, w_ir_valid, w_fill_acc, w_consume_acc;
    logic [CNT_W:0]   w_occupied;
    logic [8*TOTAL-1:0] w_flat;
    logic [127:0]     w_window;

    // Unread bytes plus the consumed prefix of the head slot: a slot is free only if this leaves a whole line.
    assign w_occupied = {1'b0, r_byte_cnt} + (CNT_W+1)'(r_rd_ptr[3:0]);

    always_comb begin
        w_fill_ready      = 1'b0;
        w_ir_valid        = 1'b0;
        w_state_next      = r_state;
        w_wr_ptr_next     = r_wr_ptr;
        w_rd_ptr_next     = r_rd_ptr;
        w_byte_cnt_next   = r_byte_cnt;
        w_fetch_addr_next = r_fetch_addr;
        w_eip_next        = r_eip;
        w_cs_next         = r_cs;

        case (r_state)
            ST_FIRST: w_fill_ready = 1'b1;
            ST_RUN: begin
                w_fill_ready = (w_occupied <= (CNT_W+1)'(LINE_BYTES * (DEPTH_LINES - 1)));
                w_ir_valid   = (r_byte_cnt >= CNT_W'(WIN_BYTES));
            end
            default: ;
        endcase

        w_fill_acc    = fill_valid & w_fill_ready & ~redirect;
        w_consume_acc = consume & w_ir_valid & (instr_length != 4'd0) & ~redirect;

        if (redirect) begin
            w_state_next      = ST_FIRST;
            w_byte_cnt_next   = '0;
            w_wr_ptr_next     = '0;
            w_rd_ptr_next     = RD_W'(redirect_eip[3:0]);
            w_eip_next        = redirect_eip;
            w_cs_next         = redirect_cs;
            w_fetch_addr_next = {redirect_eip[31:4], 4'h0};
        end else begin
            if (w_fill_acc) begin
                w_state_next      = ST_RUN;
                w_wr_ptr_next     = r_wr_ptr + 1'b1;
                w_fetch_addr_next = r_fetch_addr + 32'd16;
            end
            if (r_state == ST_FIRST) begin
                if (w_fill_acc)
                    w_byte_cnt_next = CNT_W'(LINE_BYTES) - CNT_W'(r_rd_ptr[3:0]);
            end else begin
                w_byte_cnt_next = r_byte_cnt
                                + (w_fill_acc    ? CNT_W'(LINE_BYTES)   : '0)
                                - (w_consume_acc ? CNT_W'(instr_length) : '0);
            end
            if (w_consume_acc) begin
                w_rd_ptr_next = r_rd_ptr + RD_W'(instr_length);
                w_eip_next    = r_eip + 32'(instr_length);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_byte_cnt   <= '0;
            r_fetch_addr <= '0;
            r_eip        <= '0;
            r_cs         <= '0;
        end else begin
            r_state      <= w_state_next;
            r_wr_ptr     <= w_wr_ptr_next;
            r_rd_ptr     <= w_rd_ptr_next;
            r_byte_cnt   <= w_byte_cnt_next;
            r_fetch_addr <= w_fetch_addr_next;
            r_eip        <= w_eip_next;
            r_cs         <= w_cs_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill_acc)
            r_mem[r_wr_ptr] <= fill_data;
    end

    for (genvar g = 0; g < DEPTH_LINES; g++) begin : g_flat
        assign w_flat[128*g +: 128] = r_mem[g];
    end

    byte_window_rotator #(
        .N_BYTES (TOTAL),
        .SH_W    (RD_W)
    ) u_rotator (
        .i_bytes  (w_flat),
        .i_shift  (r_rd_ptr),
        .o_window (w_window)
    );

    // Gated so the window reads as zero out of reset, when slot contents are undefined.
    assign IR         = w_ir_valid ? w_window : '0;
    assign ir_valid   = w_ir_valid;
    assign fill_ready = w_fill_ready;
    assign fetch_addr = r_fetch_addr;
    assign EIP_OUT    = r_eip;
    assign CS_OUT     = r_cs;
endmodule

// File: tb/tb_fetch_byte_queue.sv
// tb/tb_fetch_byte_queue.sv - directed self-checking bench for fetch_byte_queue
module tb_fetch_byte_queue;
    logic         clk;
    logic         reset;
    logic         redirect;
    logic [31:0]  redirect_eip;
    logic [15:0]  redirect_cs;
    logic [31:0]  fetch_addr;
    logic         fill_valid;
    logic [127:0] fill_data;
    logic         fill_ready;
    logic         ir_valid;
    logic [127:0] IR;
    logic [31:0]  EIP_OUT;
    logic [15:0]  CS_OUT;
    logic         consume;
    logic [3:0]   instr_length;

    int checks   = 0;
    int failures = 0;
    logic [31:0] m_fetch;

    fetch_byte_queue #(.DEPTH_LINES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .redirect     (redirect),
        .redirect_eip (redirect_eip),
        .redirect_cs  (redirect_cs),
        .fetch_addr   (fetch_addr),
        .fill_valid   (fill_valid),
        .fill_data    (fill_data),
        .fill_ready   (fill_ready),
        .ir_valid     (ir_valid),
        .IR           (IR),
        .EIP_OUT      (EIP_OUT),
        .CS_OUT       (CS_OUT),
        .consume      (consume),
        .instr_length (instr_length)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: every byte is a function of its own linear address.
    function automatic logic [7:0] mkbyte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [127:0] mkline(input logic [31:0] a);
        logic [127:0] l;
        for (int i = 0; i < 16; i++) l[8*i +: 8] = mkbyte(a + 32'(i));
        return l;
    endfunction

    function automatic logic [127:0] mkwin(input logic [31:0] a);
        logic [127:0] w;
        for (int i = 0; i < 16; i++) w[127-8*i -: 8] = mkbyte(a + 32'(i));
        return w;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] eip, input logic [15:0] cs);
        redirect = 1'b1; redirect_eip = eip; redirect_cs = cs;
        tick();
        redirect = 1'b0;
        m_fetch = {eip[31:4], 4'h0};
    endtask

    task automatic do_fill;
        fill_valid = 1'b1; fill_data = mkline(m_fetch);
        m_fetch = m_fetch + 32'd16;
        tick();
        fill_valid = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL rst_ir_valid actual=%0h expected=0", ir_valid); end
        checks++; if (fill_ready !== 1'b0) begin failures++; $display("FAIL rst_fill_ready actual=%0h expected=0", fill_ready); end
        checks++; if (fetch_addr !== 32'h0) begin failures++; $display("FAIL rst_fetch_addr actual=%0h expected=0", fetch_addr); end
        checks++; if (EIP_OUT !== 32'h0) begin failures++; $display("FAIL rst_eip actual=%0h expected=0", EIP_OUT); end
        checks++; if (CS_OUT !== 16'h0) begin failures++; $display("FAIL rst_cs actual=%0h expected=0", CS_OUT); end
        checks++; if (IR !== 128'h0) begin failures++; $display("FAIL rst_ir actual=%0h expected=0", IR); end
        tick();
        reset = 1'b0;
        fill_valid = 1'b1; fill_data = mkline(32'h0); consume = 1'b1; instr_length = 4'd4;
        tick();
        fill_valid = 1'b0; consume = 1'b0;
        checks++; if (fill_ready !== 1'b0) begin failures++; $display("FAIL idle_fill_ready actual=%0h expected=0", fill_ready); end
        checks++; if (fetch_addr !== 32'h0) begin failures++; $display("FAIL idle_fetch_addr actual=%0h expected=0", fetch_addr); end
    endtask

    task automatic test_first_fill;
        logic [7:0] hb;
        do_redirect(32'h0000_1003, 16'h0008);
        checks++; if (fill_ready !== 1'b1) begin failures++; $display("FAIL first_fill_ready actual=%0h expected=1", fill_ready); end
        checks++; if (EIP_OUT !== 32'h1003) begin failures++; $display("FAIL first_eip actual=%0h expected=1003", EIP_OUT); end
        checks++; if (CS_OUT !== 16'h0008) begin failures++; $display("FAIL first_cs actual=%0h expected=8", CS_OUT); end
        checks++; if (fetch_addr !== 32'h1000) begin failures++; $display("FAIL first_fetch actual=%0h expected=1000", fetch_addr); end
        do_fill();
        checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL l0_ir_valid actual=%0h expected=0", ir_valid); end
        checks++; if (fetch_addr !== 32'h1010) begin failures++; $display("FAIL l0_fetch actual=%0h expected=1010", fetch_addr); end
        do_fill();
        hb = IR[127:120];
        checks++; if (ir_valid !== 1'b1) begin failures++; $display("FAIL l1_ir_valid actual=%0h expected=1", ir_valid); end
        checks++; if (hb !== mkbyte(32'h1003)) begin failures++; $display("FAIL l1_head_byte actual=%0h expected=%0h", hb, mkbyte(32'h1003)); end
        checks++; if (IR !== mkwin(32'h1003)) begin failures++; $display("FAIL l1_ir actual=%0h expected=%0h", IR, mkwin(32'h1003)); end
        checks++; if (EIP_OUT !== 32'h1003) begin failures++; $display("FAIL l1_eip actual=%0h expected=1003", EIP_OUT); end
        checks++; if (fetch_addr !== 32'h1020) begin failures++; $display("FAIL l1_fetch actual=%0h expected=1020", fetch_addr); end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  lens [4];
        logic [31:0] eips [4];
        lens = '{4'd3, 4'd15, 4'd1, 4'd7};
        eips = '{32'h1003, 32'h1012, 32'h1013, 32'h101A};
        do_redirect(32'h0000_1000, 16'h0010);
        do_fill();
        checks++; if (EIP_OUT !== 32'h1000) begin failures++; $display("FAIL b2b_eip0 actual=%0h expected=1000", EIP_OUT); end
        checks++; if (IR !== mkwin(32'h1000)) begin failures++; $display("FAIL b2b_ir0 actual=%0h expected=%0h", IR, mkwin(32'h1000)); end
        for (int i = 0; i < 4; i++) begin
            consume = 1'b1; instr_length = lens[i];
            fill_valid = 1'b1; fill_data = mkline(m_fetch);
            m_fetch = m_fetch + 32'd16;
            tick();
            consume = 1'b0; fill_valid = 1'b0;
            checks++; if (EIP_OUT !== eips[i]) begin failures++; $display("FAIL b2b_eip[%0d] actual=%0h expected=%0h", i, EIP_OUT, eips[i]); end
            checks++; if (ir_valid !== 1'b1) begin failures++; $display("FAIL b2b_ir_valid[%0d] actual=%0h expected=1", i, ir_valid); end
            checks++; if (IR !== mkwin(eips[i])) begin failures++; $display("FAIL b2b_ir[%0d] actual=%0h expected=%0h", i, IR, mkwin(eips[i])); end
            checks++; if (fetch_addr !== m_fetch) begin failures++; $display("FAIL b2b_fetch[%0d] actual=%0h expected=%0h", i, fetch_addr, m_fetch); end
        end
    endtask

    task automatic test_full;
        int n;
        n = 0;
        do_redirect(32'h0000_2000, 16'h0018);
        fill_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            fill_data = mkline(m_fetch);
            if (fill_ready) begin n++; m_fetch = m_fetch + 32'd16; end
            tick();
        end
        fill_data = mkline(m_fetch);
        checks++; if (n !== 4) begin failures++; $display("FAIL full_lines actual=%0d expected=4", n); end
        checks++; if (fill_ready !== 1'b0) begin failures++; $display("FAIL full_ready actual=%0h expected=0", fill_ready); end
        checks++; if (fetch_addr !== 32'h2040) begin failures++; $display("FAIL full_fetch actual=%0h expected=2040", fetch_addr); end
        checks++; if (IR !== mkwin(32'h2000)) begin failures++; $display("FAIL full_ir actual=%0h expected=%0h", IR, mkwin(32'h2000)); end
        consume = 1'b1; instr_length = 4'd15;
        tick();
        checks++; if (fill_ready !== 1'b0) begin failures++; $display("FAIL full_c15_ready actual=%0h expected=0", fill_ready); end
        checks++; if (EIP_OUT !== 32'h200F) begin failures++; $display("FAIL full_c15_eip actual=%0h expected=200f", EIP_OUT); end
        instr_length = 4'd1;
        tick();
        consume = 1'b0;
        checks++; if (fill_ready !== 1'b1) begin failures++; $display("FAIL full_c1_ready actual=%0h expected=1", fill_ready); end
        checks++; if (fetch_addr !== 32'h2040) begin failures++; $display("FAIL full_held_fetch actual=%0h expected=2040", fetch_addr); end
    endtask

    task automatic test_wrap;
        logic [127:0] ir_s;
        logic [3:0]   lens [3];
        lens = '{4'd15, 4'd15, 4'd12};
        tick();
        fill_valid = 1'b0;
        m_fetch = m_fetch + 32'd16;
        checks++; if (fetch_addr !== 32'h2050) begin failures++; $display("FAIL wrap_fetch actual=%0h expected=2050", fetch_addr); end
        for (int i = 0; i < 3; i++) begin
            consume = 1'b1; instr_length = lens[i];
            tick();
        end
        consume = 1'b0;
        ir_s = IR;
        checks++; if (EIP_OUT !== 32'h203A) begin failures++; $display("FAIL wrap_eip actual=%0h expected=203a", EIP_OUT); end
        checks++; if (ir_valid !== 1'b1) begin failures++; $display("FAIL wrap_ir_valid actual=%0h expected=1", ir_valid); end
        checks++; if (ir_s[127:120] !== mkbyte(32'h203A)) begin failures++; $display("FAIL wrap_b0 actual=%0h expected=%0h", ir_s[127:120], mkbyte(32'h203A)); end
        checks++; if (ir_s[87:80] !== mkbyte(32'h203F)) begin failures++; $display("FAIL wrap_b5 actual=%0h expected=%0h", ir_s[87:80], mkbyte(32'h203F)); end
        checks++; if (ir_s[79:72] !== mkbyte(32'h2040)) begin failures++; $display("FAIL wrap_b6 actual=%0h expected=%0h", ir_s[79:72], mkbyte(32'h2040)); end
        checks++; if (ir_s !== mkwin(32'h203A)) begin failures++; $display("FAIL wrap_ir actual=%0h expected=%0h", ir_s, mkwin(32'h203A)); end
    endtask

    task automatic test_redirect_collision;
        redirect = 1'b1; redirect_eip = 32'h0000_3007; redirect_cs = 16'h0020;
        fill_valid = 1'b1; fill_data = mkline(32'h9990);
        consume = 1'b1; instr_length = 4'd5;
        tick();
        redirect = 1'b0; fill_valid = 1'b0; consume = 1'b0;
        m_fetch = 32'h3000;
        checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL coll_ir_valid actual=%0h expected=0", ir_valid); end
        checks++; if (fill_ready !== 1'b1) begin failures++; $display("FAIL coll_ready actual=%0h expected=1", fill_ready); end
        checks++; if (EIP_OUT !== 32'h3007) begin failures++; $display("FAIL coll_eip actual=%0h expected=3007", EIP_OUT); end
        checks++; if (CS_OUT !== 16'h0020) begin failures++; $display("FAIL coll_cs actual=%0h expected=20", CS_OUT); end
        checks++; if (fetch_addr !== 32'h3000) begin failures++; $display("FAIL coll_fetch actual=%0h expected=3000", fetch_addr); end
        do_fill();
        checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL coll_l0_ir_valid actual=%0h expected=0", ir_valid); end
        do_fill();
        checks++; if (ir_valid !== 1'b1) begin failures++; $display("FAIL coll_l1_ir_valid actual=%0h expected=1", ir_valid); end
        checks++; if (IR !== mkwin(32'h3007)) begin failures++; $display("FAIL coll_ir actual=%0h expected=%0h", IR, mkwin(32'h3007)); end
    endtask

    task automatic test_async_reset;
        consume = 1'b1; instr_length = 4'd2;
        fill_valid = 1'b1; fill_data = mkline(m_fetch);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL async_ir_valid actual=%0h expected=0", ir_valid); end
        checks++; if (fill_ready !== 1'b0) begin failures++; $display("FAIL async_ready actual=%0h expected=0", fill_ready); end
        checks++; if (fetch_addr !== 32'h0) begin failures++; $display("FAIL async_fetch actual=%0h expected=0", fetch_addr); end
        checks++; if (EIP_OUT !== 32'h0) begin failures++; $display("FAIL async_eip actual=%0h expected=0", EIP_OUT); end
        checks++; if (CS_OUT !== 16'h0) begin failures++; $display("FAIL async_cs actual=%0h expected=0", CS_OUT); end
        checks++; if (IR !== 128'h0) begin failures++; $display("FAIL async_ir actual=%0h expected=0", IR); end
        @(negedge clk);
        reset = 1'b0;
        tick();
        consume = 1'b0; fill_valid = 1'b0;
        checks++; if (fill_ready !== 1'b0) begin failures++; $display("FAIL post_rst_ready actual=%0h expected=0", fill_ready); end
        checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL post_rst_ir_valid actual=%0h expected=0", ir_valid); end
        do_redirect(32'h0000_4000, 16'h0028);
        checks++; if (fill_ready !== 1'b1) begin failures++; $display("FAIL post_redir_ready actual=%0h expected=1", fill_ready); end
        checks++; if (fetch_addr !== 32'h4000) begin failures++; $display("FAIL post_redir_fetch actual=%0h expected=4000", fetch_addr); end
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_eip = '0; redirect_cs = '0;
        fill_valid = 1'b0; fill_data = '0; consume = 1'b0; instr_length = '0;
        m_fetch = '0;
        test_reset();
        test_first_fill();
        test_back_to_back();
        test_full();
        test_wrap();
        test_redirect_collision();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
